fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
- Instruction-fetch front end of the pipelined CPU.
- Holds the program counter and computes PC+4 and the branch target PC+(imm<<2), each with an instance of the team's 64-bit gate-level adder.
- Selects the next PC from sequential, conditional/unconditional-immediate and register-branch sources.
- Drives the IF/ID pipeline register: PC, PC+4 and a valid bit. Honours stall and flush from the hazard unit.

Parameters:
- BITS, 64, datapath and PC width.
- RESET_PC, 64'h0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment; must be 4 (constant input to the PC+4 adder).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  hazard unit: invalidate IF/ID on the next edge.
- br_taken  input  1  ID/EX resolved immediate branch taken this cycle.
- br_pc  input  BITS  PC of the branching instruction.
- br_imm  input  BITS  sign-extended word offset (unshifted).
- reg_br  input  1  BR-to-register taken this cycle.
- reg_target  input  BITS  register branch target.
- pc_out  output  BITS  current PC to instruction memory.
- if_id_pc  output  BITS  registered PC of the fetched instruction.
- if_id_pc4  output  BITS  registered PC+4 of the fetched instruction.
- if_id_valid  output  1  IF/ID holds a live instruction.
- misalign_err  output  1  sticky: reg_target had nonzero bits [1:0].
- redirect_count  output  32  taken-redirect counter (see Optional Feature).

Behaviour:
- Reset is asynchronous on reset_n low; release takes effect at the next rising edge. While reset_n is low, mid-operation included:
  - pc_out=RESET_PC
  - if_id_pc=0, if_id_pc4=0, if_id_valid=0
  - misalign_err=0, redirect_count=0
- Adders are combinational:
  - seq = pc_out + 4.
  - tgt = br_pc + {br_imm[BITS-3:0],2'b00}; the shift is wiring only.
  - Overflow wraps modulo 2^BITS; there is no carry out.
  - Adder gate delays total under one cycle; there is no extra latency.
- Next-PC priority, evaluated each rising edge:
  1. reg_br=1 -> pc <= {reg_target[BITS-1:2],2'b00}. If reg_target[1:0]!=0, misalign_err <= 1, sticky until reset.
  2. br_taken=1 -> pc <= tgt.
  3. stall=1 -> pc holds.
  4. Otherwise pc <= seq.
- Redirects (reg_br or br_taken) override stall. A redirect means the stalled wrong-path instruction must not be retained.
- If reg_br and br_taken are both 1, reg_br wins.
- IF/ID register, each rising edge:
  - flush=1 or any redirect -> if_id_valid <= 0. if_id_pc and if_id_pc4 are loaded from the current pc and seq anyway; this is don't-care, but the bench expects the loaded values.
  - else stall=1 -> all IF/ID fields hold.
  - else -> if_id_pc <= pc_out, if_id_pc4 <= seq, if_id_valid <= 1.
- Fetch latency: a PC presented on pc_out in cycle N appears on if_id_pc after edge N+1. The first valid instruction after reset release has if_id_pc=RESET_PC.
- pc_out is the registered PC, not a combinational next-PC.
- Wrap-around: pc=64'hFFFF_FFFF_FFFF_FFFC with sequential fetch gives next pc=0. There is no error.

Optional Feature:
- Macro FETCH_REDIRECT_COUNT_EN.
- Defined:
  - redirect_count increments by 1 on every edge where reg_br or br_taken is 1 and reset_n is high.
  - It saturates at 32'hFFFF_FFFF; no wrap.
- Undefined: redirect_count is tied to 0 and the counter logic is absent. All other behaviour is identical.

Test Plan:
- Reset then run: hold reset_n=0, release, run 3 cycles with no control inputs -> pc_out 0,4,8,12. if_id_valid first 1 with if_id_pc=0, if_id_pc4=4.
- Immediate branch: br_taken=1, br_pc=0x40, br_imm=-4 for one cycle -> next pc_out=0x30. if_id_valid=0 for that edge, then 1 with if_id_pc=0x30.
- Stall vs redirect: stall=1 at pc=0x20 for 2 cycles -> pc and IF/ID hold. Then stall=1 together with reg_br=1, reg_target=0x103 -> pc=0x100, misalign_err=1 (stays 1), if_id_valid=0.
- Flush alone: flush=1 at pc=0x8 -> pc advances to 0xC, if_id_valid=0 for one cycle.
- Wrap and mid-run reset: pc=0xFFFF_FFFF_FFFF_FFFC -> next pc=0. Drop reset_n mid-cycle -> all outputs take reset values immediately, without waiting for a clock edge.
- Counter (macro defined): 5 redirect cycles, including one with reg_br and br_taken both 1 -> redirect_count=5. With the counter preloaded near saturation via force, the count stays at 32'hFFFF_FFFF. Macro undefined -> redirect_count=0 throughout.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch front end: PC register, PC+4 and branch-target adders, next-PC select, IF/ID register.
// Optional: define FETCH_REDIRECT_COUNT_EN to build the saturating taken-redirect counter.

module fetch_pc_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    // Ripple-carry chain; the final carry out is dropped so sums wrap modulo 2^W.
    logic [W-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < W - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end
endmodule

module fetch_pc_stage #(
    parameter int              BITS        = 64,
    parameter logic [BITS-1:0] RESET_PC    = '0,
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            br_taken,
    input  logic [BITS-1:0] br_pc,
    input  logic [BITS-1:0] br_imm,
    input  logic            reg_br,
    input  logic [BITS-1:0] reg_target,
    output logic [BITS-1:0] pc_out,
    output logic [BITS-1:0] if_id_pc,
    output logic [BITS-1:0] if_id_pc4,
    output logic            if_id_valid,
    output logic            misalign_err,
    output logic [31:0]     redirect_count
);
    localparam logic [BITS-1:0] INCR = BITS'(INSTR_BYTES);

    logic [BITS-1:0] pc_q, pc_d;
    logic [BITS-1:0] if_id_pc_q, if_id_pc_d;
    logic [BITS-1:0] if_id_pc4_q, if_id_pc4_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            misalign_q, misalign_d;

    logic [BITS-1:0] seq;
    logic [BITS-1:0] tgt;
    logic [BITS-1:0] imm_shifted;
    logic            redirect;
    logic [1:0]      unused_imm_hi;

    // Word offset becomes a byte offset by wiring; the top two imm bits fall off.
    assign imm_shifted   = {br_imm[BITS-3:0], 2'b00};
    assign unused_imm_hi = br_imm[BITS-1:BITS-2];
    assign redirect      = reg_br | br_taken;

    fetch_pc_adder #(.W(BITS)) u_seq_adder (
        .a   (pc_q),
        .b   (INCR),
        .sum (seq)
    );

    fetch_pc_adder #(.W(BITS)) u_tgt_adder (
        .a   (br_pc),
        .b   (imm_shifted),
        .sum (tgt)
    );

    // Redirects beat stall: the stalled instruction is on the wrong path anyway.
    always_comb begin
        pc_d       = seq;
        misalign_d = misalign_q;
        if (reg_br) begin
            pc_d       = {reg_target[BITS-1:2], 2'b00};
            misalign_d = misalign_q | (|reg_target[1:0]);
        end else if (br_taken) begin
            pc_d = tgt;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        if_id_pc_d    = pc_q;
        if_id_pc4_d   = seq;
        if_id_valid_d = 1'b1;
        if (flush || redirect) begin
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            if_id_pc_d    = if_id_pc_q;
            if_id_pc4_d   = if_id_pc4_q;
            if_id_valid_d = if_id_valid_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            misalign_q    <= misalign_d;
        end
    end

`ifdef FETCH_REDIRECT_COUNT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_cnt_q <= 32'd0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_count = redirect_cnt_q;
`else
    assign redirect_count = 32'd0;
`endif

    assign pc_out       = pc_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_pc4    = if_id_pc4_q;
    assign if_id_valid  = if_id_valid_q;
    assign misalign_err = misalign_q;
endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: reset, branches, stall/redirect, flush, wrap, mid-run reset, redirect counter.
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.

module tb_fetch_pc_stage;
    localparam int BITS = 64;
`ifdef FETCH_REDIRECT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            stall;
    logic            flush;
    logic            br_taken;
    logic [BITS-1:0] br_pc;
    logic [BITS-1:0] br_imm;
    logic            reg_br;
    logic [BITS-1:0] reg_target;
    logic [BITS-1:0] pc_out;
    logic [BITS-1:0] if_id_pc;
    logic [BITS-1:0] if_id_pc4;
    logic            if_id_valid;
    logic            misalign_err;
    logic [31:0]     redirect_count;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [193:0] obs;
    logic [193:0] exp_v;
    logic [31:0]  exp_cnt;

    always #5 clk = ~clk;

    fetch_pc_stage #(.BITS(BITS), .RESET_PC(64'h0), .INSTR_BYTES(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .br_taken       (br_taken),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .reg_br         (reg_br),
        .reg_target     (reg_target),
        .pc_out         (pc_out),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .misalign_err   (misalign_err),
        .redirect_count (redirect_count)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctrl();
        stall      = 1'b0;
        flush      = 1'b0;
        br_taken   = 1'b0;
        br_pc      = '0;
        br_imm     = '0;
        reg_br     = 1'b0;
        reg_target = '0;
    endtask

    // Fields compared together: {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err}
    task automatic test_reset();
        clear_ctrl();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h0, 64'h0, 64'h0, 1'b0, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL reset_state got=%h exp=%h", obs, exp_v); else n_pass++;
        n_total++; if (redirect_count !== 32'd0) $display("FAIL reset_count got=%h exp=%h", redirect_count, 32'd0); else n_pass++;
        reset_n = 1'b1;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h4, 64'h0, 64'h4, 1'b1, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL run_1 got=%h exp=%h", obs, exp_v); else n_pass++;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h8, 64'h4, 64'h8, 1'b1, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL run_2 got=%h exp=%h", obs, exp_v); else n_pass++;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'hC, 64'h8, 64'hC, 1'b1, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL run_3 got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_imm_branch();
        br_taken = 1'b1;
        br_pc    = 64'h40;
        br_imm   = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h30, 64'hC, 64'h10, 1'b0, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL imm_branch got=%h exp=%h", obs, exp_v); else n_pass++;
        clear_ctrl();
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h34, 64'h30, 64'h34, 1'b1, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL imm_branch_fetch got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_stall_redirect();
        br_taken = 1'b1;
        br_pc    = 64'h1C;
        step();
        clear_ctrl();
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h20, 64'h1C, 64'h20, 1'b1, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL stall_setup got=%h exp=%h", obs, exp_v); else n_pass++;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
            n_total++; if (obs !== exp_v) $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
        end
        reg_br     = 1'b1;
        reg_target = 64'h103;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h100, 64'h20, 64'h24, 1'b0, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL stall_reg_br got=%h exp=%h", obs, exp_v); else n_pass++;
        clear_ctrl();
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h104, 64'h100, 64'h104, 1'b1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL misalign_sticky got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_flush();
        reg_br     = 1'b1;
        reg_target = 64'h8;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h8, 64'h104, 64'h108, 1'b0, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL flush_setup got=%h exp=%h", obs, exp_v); else n_pass++;
        clear_ctrl();
        flush = 1'b1;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'hC, 64'h8, 64'hC, 1'b0, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL flush got=%h exp=%h", obs, exp_v); else n_pass++;
        flush = 1'b0;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h10, 64'hC, 64'h10, 1'b1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL flush_after got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        br_taken = 1'b1;
        br_pc    = 64'h4;
        br_imm   = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 64'h14, 1'b0, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL neg_target got=%h exp=%h", obs, exp_v); else n_pass++;
        clear_ctrl();
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 1'b1};
        n_total++; if (obs !== exp_v) $display("FAIL pc_wrap got=%h exp=%h", obs, exp_v); else n_pass++;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h0, 64'h0, 64'h0, 1'b0, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL async_reset got=%h exp=%h", obs, exp_v); else n_pass++;
        n_total++; if (redirect_count !== 32'd0) $display("FAIL async_reset_count got=%h exp=%h", redirect_count, 32'd0); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h4, 64'h0, 64'h4, 1'b1, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL reset_release got=%h exp=%h", obs, exp_v); else n_pass++;
    endtask

    task automatic test_redirect_count();
        br_taken = 1'b1; br_pc = 64'h100; br_imm = 64'h1;
        step();
        clear_ctrl();
        reg_br = 1'b1; reg_target = 64'h200;
        step();
        br_taken = 1'b1; br_pc = 64'h100; br_imm = 64'h1; reg_target = 64'h300;
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h300, 64'h200, 64'h204, 1'b0, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL reg_br_wins got=%h exp=%h", obs, exp_v); else n_pass++;
        clear_ctrl();
        br_taken = 1'b1; br_pc = 64'h300; br_imm = 64'h4;
        step();
        clear_ctrl();
        reg_br = 1'b1; reg_target = 64'h400;
        step();
        clear_ctrl();
        step();
        obs = {pc_out, if_id_pc, if_id_pc4, if_id_valid, misalign_err};
        exp_v = {64'h404, 64'h400, 64'h404, 1'b1, 1'b0};
        n_total++; if (obs !== exp_v) $display("FAIL count_seq_pc got=%h exp=%h", obs, exp_v); else n_pass++;
        exp_cnt = CNT_EN ? 32'd5 : 32'd0;
        n_total++; if (redirect_count !== exp_cnt) $display("FAIL count_five got=%h exp=%h", redirect_count, exp_cnt); else n_pass++;
`ifdef FETCH_REDIRECT_COUNT_EN
        force dut.redirect_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.redirect_cnt_q;
`endif
        br_taken = 1'b1;
        step();
        exp_cnt = CNT_EN ? 32'hFFFF_FFFE : 32'd0;
        n_total++; if (redirect_count !== exp_cnt) $display("FAIL count_near_sat got=%h exp=%h", redirect_count, exp_cnt); else n_pass++;
        step();
        step();
        exp_cnt = CNT_EN ? 32'hFFFF_FFFF : 32'd0;
        n_total++; if (redirect_count !== exp_cnt) $display("FAIL count_saturate got=%h exp=%h", redirect_count, exp_cnt); else n_pass++;
        clear_ctrl();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_imm_branch();
        test_stall_redirect();
        test_flush();
        test_wrap_and_reset();
        test_redirect_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
